// File: rtl/alu_issue_seq_if.sv
// Issue/execute/writeback bus between an instruction source and alu_issue_seq.
// Carries the instruction handshake, the alu_32 operand/result path, writeback and debug read.
// master = instruction source and alu_32 side; slave = the sequencer.
interface alu_issue_seq_if #(
  parameter int WIDTH = 32
);
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [31:0]      alu_inst;
  logic [WIDTH-1:0] alu_res;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             illegal;
  logic [31:0]      instret;
  logic [4:0]       dbg_addr;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output instr_valid, instr, alu_res, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_inst, wb_valid, wb_rd, wb_data,
           illegal, instret, dbg_data
  );

  modport slave (
    input  instr_valid, instr, alu_res, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_inst, wb_valid, wb_rd, wb_data,
           illegal, instret, dbg_data
  );
endinterface

// File: rtl/alu_issue_seq.sv
// Serial RV32 ALU issue sequencer: regfile read, drive alu_32, capture result, write back.
// Latency: writeback pulse 2+EXEC_CYCLES cycles after acceptance; one instruction per 3+EXEC_CYCLES.
// Backpressure: instr_ready is high only in IDLE; the source holds instr until accepted.
module alu_issue_seq #(
  parameter int WIDTH       = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  alu_issue_seq_if.slave bus
);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam int         CW   = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t           state;
  logic [31:0]      instr_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] regs [32];

  logic             is_r;
  logic [WIDTH-1:0] imm_sext;

  assign is_r     = (instr_q[6:0] == OP_R);
  assign imm_sext = {{(WIDTH-12){instr_q[31]}}, instr_q[31:20]};

  // Debug port reads the regfile directly; x0 is hard-wired to zero.
  assign bus.dbg_data = (bus.dbg_addr == 5'd0) ? '0 : regs[bus.dbg_addr];

  // Sequencer FSM with registered outputs and the register file it owns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      instr_q         <= '0;
      cnt             <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      bus.instr_ready <= 1'b1;
      bus.alu_a       <= '0;
      bus.alu_b       <= '0;
      bus.alu_inst    <= '0;
      bus.wb_valid    <= 1'b0;
      bus.wb_rd       <= '0;
      bus.wb_data     <= '0;
      bus.illegal     <= 1'b0;
      bus.instret     <= '0;
    end else begin
      bus.wb_valid <= 1'b0;
      bus.illegal  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.instr_valid && bus.instr_ready) begin
            if (bus.instr[6:0] == OP_R || bus.instr[6:0] == OP_I) begin
              instr_q         <= bus.instr;
              bus.instr_ready <= 1'b0;
              state           <= DECODE;
            end else begin
              // Unsupported opcode is dropped; ready stays high.
              bus.illegal <= 1'b1;
            end
          end
        end
        DECODE: begin
          bus.alu_a    <= regs[instr_q[19:15]];
          bus.alu_b    <= is_r ? regs[instr_q[24:20]] : imm_sext;
          bus.alu_inst <= instr_q;
          cnt          <= CW'(EXEC_CYCLES - 1);
          state        <= EXEC;
        end
        EXEC: begin
          if (cnt == '0) begin
            bus.wb_data  <= bus.alu_res;
            bus.wb_rd    <= instr_q[11:7];
            bus.wb_valid <= 1'b1;
            state        <= WB;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WB: begin
          if (bus.wb_rd != 5'd0) regs[bus.wb_rd] <= bus.wb_data;
          bus.instret     <= bus.instret + 32'd1;
          bus.instr_ready <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Sequencer on the driving side of alu_32. Accepts one RV32 R-type (opcode 0110011) or I-type ALU (opcode 0010011) instruction at a time through a valid/ready handshake.
- Reads operands from an internal 32x32 register file and presents a, b and inst to alu_32.
- Captures alu_32's result and writes it back to rd.
- Serves as the execute/writeback core of the single-issue datapath; alu_32 itself stays outside this block.

Parameters:
- WIDTH, 32, data/register width; only 32 is supported.
- EXEC_CYCLES, 1, cycles spent in EXEC before capturing alu_res; must be >=1. Allows margin for the multiplier path.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept an instruction
- instr  in  32  instruction word
- alu_a  out  WIDTH  operand a to alu_32
- alu_b  out  WIDTH  operand b to alu_32
- alu_inst  out  32  instruction to alu_32
- alu_res  in  WIDTH  alu_32 out
- wb_valid  out  1  one-cycle pulse: writeback occurring
- wb_rd  out  5  destination register of writeback
- wb_data  out  WIDTH  value written
- illegal  out  1  one-cycle pulse: unsupported opcode dropped
- instret  out  32  retired-instruction counter
- dbg_addr  in  5  debug read address
- dbg_data  out  WIDTH  combinational read of regfile[dbg_addr]; x0 always reads 0

Behaviour:
- Reset (async, takes effect immediately; also mid-operation):
  - FSM goes to IDLE.
  - All 32 registers cleared to 0.
  - alu_a, alu_b, alu_inst, wb_rd, wb_data, instret = 0.
  - wb_valid, illegal = 0; instr_ready = 1.
  - Any in-flight instruction is discarded with no writeback.
- States: IDLE, DECODE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - Handshake occurs on a rising edge with instr_valid&&instr_ready; instr is latched.
  - Opcode (instr[6:0]) 0110011 or 0010011 -> DECODE.
  - Any other opcode -> illegal=1 for the next cycle, stay IDLE, no register change, instret unchanged.
- DECODE (1 cycle):
  - instr_ready=0.
  - Register alu_a <= regfile[rs1] (rs1=instr[19:15]).
  - R-type: alu_b <= regfile[rs2] (rs2=instr[24:20]).
  - I-type: alu_b <= sign-extended instr[31:20].
  - alu_inst <= latched instr.
  - Load EXEC counter with EXEC_CYCLES-1, then -> EXEC.
- EXEC:
  - alu_a, alu_b and alu_inst are held stable; the counter decrements each cycle.
  - When the counter is 0: wb_data <= alu_res, wb_rd <= instr[11:7], then -> WB.
- WB (1 cycle):
  - wb_valid=1.
  - regfile[wb_rd] <= wb_data at the end of the cycle; suppressed when wb_rd==0, but wb_valid still pulses.
  - instret increments, wrapping 0xFFFFFFFF -> 0.
  - -> IDLE.
- Timing, with acceptance edge = cycle 0:
  - DECODE is cycle 1; EXEC is cycles 2..1+EXEC_CYCLES; wb_valid is high in cycle 2+EXEC_CYCLES.
  - instr_ready is high again in the following cycle.
  - Throughput is one instruction per 3+EXEC_CYCLES cycles.
- Register file:
  - Reads in DECODE see all prior writebacks, so no hazards arise because issue is serial.
  - rs1==rs2==rd is legal.
- instr_valid while instr_ready=0 is ignored; the source holds the instruction until accepted.
- The instr value is don't-care when instr_valid=0.
- dbg_data reflects a writeback from the cycle after the WB edge.

Test Plan:
- Reset, then ADDI x1,x0,0x128 (instr 0x12800093) -> wb_valid in cycle 3 after acceptance, wb_rd=1, wb_data=0x00000128, dbg_data(1)=0x128, instret=1.
- ADDI x2,x0,-1 (0xFFF00113); then SUB x3,x1,x2 (0x402081B3) -> x2=0xFFFFFFFF, x3=0x00000129. Check that alu_a/alu_b are held stable through EXEC and that instr_ready is low from DECODE through WB.
- ADDI x0,x0,5 (0x00500013) -> wb_valid pulses with wb_rd=0, dbg_data(0)=0, instret increments.
- Offer opcode 0x03 (load, 0x00002083) -> illegal pulses 1 cycle, no wb_valid, regfile and instret unchanged, instr_ready stays 1.
- EXEC_CYCLES=4, ANDI x4,x1,0x0F0 (0x0F00F213) with x1=0x128 -> wb_valid 6 cycles after acceptance, wb_data=0x20.
- Assert rst during EXEC of an ADDI -> outputs and registers immediately 0, no wb_valid; the next instruction executes normally.
